mem_cmd_responder: RTL
======================

Name: mem_cmd_responder

Overview:
- Memory-side end of the IO-controller command interface.
- Accepts read, write and clear commands signalled by io_done and mode, and executes them against a single-port word memory through a req/ack device port.
- Returns read data on mem_out and holds mem_done low while a command is in flight.
- Sits between the IO controller and the SDRAM/SRAM device controller.

Parameters:
- ADDR_W, 25, word address width (matches memoryAddress).
- DATA_W, 16, data word width.
- CLEAR_WORDS, 1024, number of words zeroed by a clear sweep, starting at address 0.
- TIMEOUT_CYC, 255, cycles allowed for dev_ack before abort (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2  00 clear, 01 read, 10 write, 11 idle
- io_done  in  1  command strobe, level; the rising edge starts the command
- mem_addr  in  ADDR_W  command address
- io_data_in  in  DATA_W  write data
- mem_done  out  1  1 = ready/idle, 0 = busy
- mem_out  out  DATA_W  last read data
- dev_req  out  1  device request
- dev_we  out  1  1 = write
- dev_addr  out  ADDR_W  device address
- dev_wdata  out  DATA_W  device write data
- dev_rdata  in  DATA_W  device read data, valid in the dev_ack cycle
- dev_ack  in  1  one-cycle completion from the device
- err  out  1  sticky timeout flag (optional feature only)

Behaviour:
- Reset values: mem_done=1, mem_out=0, dev_req=0, dev_we=0, dev_addr=0, dev_wdata=0, err=0. FSM goes to IDLE. Edge-detect registers are loaded with the current io_done and mode, so reset itself produces no false trigger.
- Reset mid-operation aborts immediately: dev_req drops asynchronously and no partial state survives.
- Triggers in IDLE:
  - Rising io_done with mode 01 or 10 → ISSUE. mode, mem_addr and io_data_in are latched that cycle.
  - mode changing to 00 from any other value → CLR_ISSUE with clear counter = 0.
  - mode 11 with rising io_done → ignored.
  - io_done rising in the same cycle mode enters 00 → clear takes priority.
- Triggers while busy (state ≠ IDLE) are ignored and not queued. The edge detectors keep updating, so an edge that occurs while busy is lost.
- mem_done goes 0 on the cycle after a trigger. It returns to 1 on the cycle after the final dev_ack.
- ISSUE: dev_req=1 with dev_we/addr/wdata from the latched values → WAIT.
- WAIT:
  - dev_req, dev_we, dev_addr and dev_wdata are held stable until dev_ack=1.
  - On dev_ack: dev_req=0. For a read, mem_out <= dev_rdata. Then → IDLE.
  - Minimum latency, trigger edge to mem_done=1, is 3 cycles with a same-cycle ack.
- CLR_ISSUE / CLR_WAIT:
  - Write 0 to address = counter.
  - On dev_ack, if counter == CLEAR_WORDS-1 → IDLE and mem_out <= 0. Otherwise counter+1 → CLR_ISSUE.
  - dev_req deasserts for one cycle between words.
  - Counter width is $clog2(CLEAR_WORDS)+1, zero-extended to ADDR_W.
- dev_ack outside WAIT/CLR_WAIT is ignored.
- mem_out changes only on a read completion or a clear completion.

Optional Feature:
- Macro: MEM_RESP_TIMEOUT_EN.
- With the macro defined: a counter runs in WAIT and CLR_WAIT. If it reaches TIMEOUT_CYC without dev_ack, the responder sets dev_req=0 and err=1, leaves mem_out unchanged, and returns to IDLE (mem_done=1). A clear sweep is abandoned. err clears only on rst.
- Without the macro: no counter, err is tied to 0, and the responder waits indefinitely.

Decomposition:
- Package mem_if_pkg holds:
  - mode_e enum (MODE_CLEAR=2'b00, MODE_READ=2'b01, MODE_WRITE=2'b10, MODE_IDLE=2'b11);
  - the responder state enum (IDLE, ISSUE, WAIT, CLR_ISSUE, CLR_WAIT);
  - default ADDR_W/DATA_W constants.
- One sub-module, mem_edge_detect: registered rising-edge and change detector, asynchronous reset, used for both io_done and mode.

Test Plan:
- Write then read: mode=10, addr=0x0001234, data=0xBEEF, pulse io_done; the device model acks 2 cycles after req → dev_we=1, dev_addr=0x0001234, dev_wdata=0xBEEF. Then mode=01 with the same address → mem_out=0xBEEF, and mem_done is 0 for exactly 4 cycles.
- Clear sweep: CLEAR_WORDS=8, mode 01→00 → 8 writes of 0 to addresses 0..7 in order, dev_req low 1 cycle between words, mem_out=0 and mem_done=1 at the end.
- Busy collision: a second io_done edge arrives during WAIT → no second dev_req is issued and mem_done returns high after the first ack only.
- Reset mid-WAIT: assert rst between edges while dev_req=1 → dev_req=0 and mem_done=1 immediately; a later dev_ack is ignored and mem_out is unchanged.
- Idle/ignored: mode=11 with an io_done edge, and a stray dev_ack in IDLE → no dev_req, mem_out unchanged.
- MEM_RESP_TIMEOUT_EN with TIMEOUT_CYC=10: the device never acks a read → dev_req drops after 10 cycles, err=1, mem_done=1, mem_out unchanged.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the IO-controller / memory-responder command interface.
package mem_if_pkg;

    localparam int MEM_ADDR_W = 25;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        MODE_CLEAR = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10,
        MODE_IDLE  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT      = 3'd2,
        CLR_ISSUE = 3'd3,
        CLR_WAIT  = 3'd4
    } resp_state_e;

endpackage

// File: rtl/mem_edge_detect.sv
// Registered edge/change detector. The history register follows the input even during
// reset, and events stay masked until the first clock after reset, so reset never fires one.
module mem_edge_detect #(
    parameter int   W         = 1,
    parameter logic RISE_ONLY = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic         o_evt
);

    logic [W-1:0] r_prev;
    logic         r_armed;

    always_ff @(posedge clk) begin
        r_prev <= i_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // RISE_ONLY looks at bit 0 only; otherwise any change of the whole vector is an event.
    assign o_evt = r_armed & (RISE_ONLY ? (i_d[0] & ~r_prev[0]) : (i_d != r_prev));

endmodule

// File: rtl/mem_cmd_responder.sv
// Memory-side command responder: turns io_done/mode commands into req/ack device accesses.
// Optional device-ack timeout with sticky err is built when MEM_RESP_TIMEOUT_EN is defined.
//
// Device handshake: dev_req is raised with dev_we/dev_addr/dev_wdata and all four are held
// stable until the device returns a one-cycle dev_ack; read data is taken in the ack cycle.
module mem_cmd_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int CLEAR_WORDS = 1024
`ifdef MEM_RESP_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              io_done,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] io_data_in,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_out,
    output logic              dev_req,
    output logic              dev_we,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [DATA_W-1:0] dev_wdata,
    input  logic [DATA_W-1:0] dev_rdata,
    input  logic              dev_ack,
    output logic              err,
    output resp_state_e       dbg_state
);

    localparam int CNT_W = $clog2(CLEAR_WORDS) + 1;

    resp_state_e       r_state;
    logic              r_mem_done;
    logic [DATA_W-1:0] r_mem_out;
    logic              r_dev_req;
    logic              r_dev_we;
    logic [ADDR_W-1:0] r_dev_addr;
    logic [DATA_W-1:0] r_dev_wdata;
    logic [CNT_W-1:0]  r_clr_cnt;

    logic w_io_rise;
    logic w_mode_chg;
    logic w_clr_trig;
    logic w_cmd_trig;
    logic w_timeout;

    mem_edge_detect #(.W(1), .RISE_ONLY(1'b1)) u_io_edge (
        .clk   (clk),
        .rst   (rst),
        .i_d   (io_done),
        .o_evt (w_io_rise)
    );

    mem_edge_detect #(.W(2), .RISE_ONLY(1'b0)) u_mode_edge (
        .clk   (clk),
        .rst   (rst),
        .i_d   (mode),
        .o_evt (w_mode_chg)
    );

    assign w_clr_trig = w_mode_chg && (mode == MODE_CLEAR);
    assign w_cmd_trig = w_io_rise && ((mode == MODE_READ) || (mode == MODE_WRITE));

`ifdef MEM_RESP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    logic            w_waiting;

    assign w_waiting = (r_state == WAIT) || (r_state == CLR_WAIT);
    assign w_timeout = w_waiting && !dev_ack && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_waiting && !dev_ack) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_done  <= 1'b1;
            r_mem_out   <= '0;
            r_dev_req   <= 1'b0;
            r_dev_we    <= 1'b0;
            r_dev_addr  <= '0;
            r_dev_wdata <= '0;
            r_clr_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Clear wins over a simultaneous io_done edge.
                    if (w_clr_trig) begin
                        r_state    <= CLR_ISSUE;
                        r_clr_cnt  <= '0;
                        r_mem_done <= 1'b0;
                    end else if (w_cmd_trig) begin
                        r_state     <= ISSUE;
                        r_dev_we    <= (mode == MODE_WRITE);
                        r_dev_addr  <= mem_addr;
                        r_dev_wdata <= io_data_in;
                        r_mem_done  <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_dev_req <= 1'b1;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (dev_ack) begin
                        r_dev_req  <= 1'b0;
                        r_mem_done <= 1'b1;
                        r_state    <= IDLE;
                        if (!r_dev_we) begin
                            r_mem_out <= dev_rdata;
                        end
                    end else if (w_timeout) begin
                        r_dev_req  <= 1'b0;
                        r_mem_done <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                CLR_ISSUE: begin
                    r_dev_req   <= 1'b1;
                    r_dev_we    <= 1'b1;
                    r_dev_addr  <= ADDR_W'(r_clr_cnt);
                    r_dev_wdata <= '0;
                    r_state     <= CLR_WAIT;
                end
                CLR_WAIT: begin
                    if (dev_ack) begin
                        r_dev_req <= 1'b0;
                        if (r_clr_cnt == CNT_W'(CLEAR_WORDS - 1)) begin
                            r_mem_out  <= '0;
                            r_mem_done <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + CNT_W'(1);
                            r_state   <= CLR_ISSUE;
                        end
                    end else if (w_timeout) begin
                        r_dev_req  <= 1'b0;
                        r_mem_done <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_dev_req  <= 1'b0;
                    r_mem_done <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign mem_done  = r_mem_done;
    assign mem_out   = r_mem_out;
    assign dev_req   = r_dev_req;
    assign dev_we    = r_dev_we;
    assign dev_addr  = r_dev_addr;
    assign dev_wdata = r_dev_wdata;
    assign dbg_state = r_state;

endmodule
